// File: rtl/nv_ram_pkg.sv
// Shared definitions for the nv_ram family.
//   clog2   : ceiling log2, used to size address ports (returns 0 for n<=1)
//   state_t : clear-sequencer states
package nv_ram_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/nv_ram_rwsp_gen.sv
// Single-port-per-direction RAM: one read port, one segment-masked write port.
// Optional output register, optional write-first bypass on collision, and
// optional zero-fill sequence after reset.
//
// Ports
//   clk            sole clock
//   rstn           synchronous active-low reset
//   ra, re         read address / enable (result in rd_q next cycle)
//   ore            output-register load enable (OUT_REG=1 only)
//   dout, dout_vld read data and "a read has completed" flag
//   wa, we, wmask  write address / enable / per-segment enable
//   di             write data
//   busy           clear sequence running; re/we ignored
//   pwrbus_ram_pd  power-domain control, no functional effect
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_CLEAR | zero-filling M[cnt], cnt = 0..DEPTH-1, busy=1
// ST_RUN   | normal read/write operation
module nv_ram_rwsp_gen
   import nv_ram_pkg::*;
#(
   parameter int DEPTH          = 32,
   parameter int WIDTH          = 128,
   parameter int SEG_W          = 8,
   parameter int OUT_REG        = 0,
   parameter int BYPASS         = 0,
   parameter int CLEAR_ON_RESET = 0,
   localparam int AW            = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
   localparam int NSEG          = WIDTH / SEG_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [AW-1:0]     ra,
   input  logic              re,
   input  logic              ore,
   output logic [WIDTH-1:0]  dout,
   output logic              dout_vld,
   input  logic [AW-1:0]     wa,
   input  logic              we,
   input  logic [NSEG-1:0]   wmask,
   input  logic [WIDTH-1:0]  di,
   output logic              busy,
   input  logic [31:0]       pwrbus_ram_pd
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state, state_nx;
   logic [AW-1:0]    cnt, cnt_nx;
   logic             ra_ok, wa_ok;
   logic             rd_acc, wr_acc, clr_en;
   logic [WIDTH-1:0] rd_nx;
   logic [WIDTH-1:0] rd_q;
   logic             rd_vld;
   logic             unused_in;

   assign unused_in = ^{pwrbus_ram_pd, ore};

   // When DEPTH fills the address space every address is legal; the
   // explicit compare is only built for partially populated spaces.
   if (DEPTH == (1 << AW)) begin : g_full
      assign ra_ok = 1'b1;
      assign wa_ok = 1'b1;
   end else begin : g_part
      assign ra_ok = ({1'b0, ra} < (AW+1)'(DEPTH));
      assign wa_ok = ({1'b0, wa} < (AW+1)'(DEPTH));
   end

   assign busy   = (state == ST_CLEAR);
   assign rd_acc = rstn && !busy && re;
   assign wr_acc = rstn && !busy && we && wa_ok;
   assign clr_en = rstn && busy;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_CLEAR: begin
            if (cnt == LAST) begin
               state_nx = ST_RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + AW'(1);
            end
         end
         default: ;
      endcase
   end

   // Array has no reset so it maps onto block RAM; zero-fill goes through
   // the ordinary write path one word per cycle.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[cnt] <= '0;
      end else if (wr_acc) begin
         for (int s = 0; s < NSEG; s++) begin
            if (wmask[s]) mem[wa][s*SEG_W +: SEG_W] <= di[s*SEG_W +: SEG_W];
         end
      end
   end

   // Out-of-range reads return zero. With BYPASS the masked segments of a
   // same-cycle write to the same word are forwarded into the read result.
   always_comb begin
      rd_nx = '0;
      if (ra_ok) begin
         rd_nx = mem[ra];
         if ((BYPASS != 0) && we && wa_ok && (wa == ra)) begin
            for (int s = 0; s < NSEG; s++) begin
               if (wmask[s]) rd_nx[s*SEG_W +: SEG_W] = di[s*SEG_W +: SEG_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_q   <= '0;
         rd_vld <= 1'b0;
      end else if (rd_acc) begin
         rd_q   <= rd_nx;
         rd_vld <= 1'b1;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] out_q;
      logic             out_vld;

      always_ff @(posedge clk) begin
         if (!rstn) begin
            out_q   <= '0;
            out_vld <= 1'b0;
         end else if (ore) begin
            out_q <= rd_q;
            if (rd_vld) out_vld <= 1'b1;
         end
      end

      assign dout     = out_q;
      assign dout_vld = out_vld;
   end else begin : g_noreg
      assign dout     = rd_q;
      assign dout_vld = rd_vld;
   end

endmodule

// File: tb/tb_nv_ram_rwsp_gen.sv
// Drives two RAM instances with identical stimulus:
//   u_a : read-first, no output register
//   u_b : write-first bypass, output register
// Both have DEPTH=20 (so addresses 20..31 are out of range) and zero-fill.
module tb_nv_ram_rwsp_gen;

   localparam int D = 20;

   logic        clk;
   logic        rstn;
   logic [4:0]  ra, wa;
   logic        re, we, ore;
   logic [3:0]  wmask;
   logic [31:0] di;
   logic [31:0] pwr;
   logic [31:0] dout_a, dout_b;
   logic        vld_a, vld_b, busy_a, busy_b;

   nv_ram_rwsp_gen #(.DEPTH(D), .WIDTH(32), .SEG_W(8), .OUT_REG(0),
                     .BYPASS(0), .CLEAR_ON_RESET(1)) u_a (
      .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
      .dout(dout_a), .dout_vld(vld_a), .wa(wa), .we(we), .wmask(wmask),
      .di(di), .busy(busy_a), .pwrbus_ram_pd(pwr));

   nv_ram_rwsp_gen #(.DEPTH(D), .WIDTH(32), .SEG_W(8), .OUT_REG(1),
                     .BYPASS(1), .CLEAR_ON_RESET(1)) u_b (
      .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
      .dout(dout_b), .dout_vld(vld_b), .wa(wa), .we(we), .wmask(wmask),
      .di(di), .busy(busy_b), .pwrbus_ram_pd(pwr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dout_a, dout_b;
      logic        vld_a, vld_b, busy_a, busy_b;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // Behavioural reference, index 0 = u_a, 1 = u_b.
   logic [31:0] m_mem [2][D];
   logic [31:0] m_rd  [2];
   logic        m_rdv [2];
   logic [31:0] m_out [2];
   logic        m_outv[2];
   logic        m_busy[2];
   int          m_cnt [2];
   const int    BYP [2] = '{0, 1};
   const int    OREG[2] = '{0, 1};

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0]  m);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic step(input logic r_n, input logic r_e, input int r_a,
                       input logic o_e, input logic w_e, input int w_a,
                       input logic [3:0] w_m, input logic [31:0] d_i);
      exp_t e;
      @(negedge clk);
      rstn = r_n; re = r_e; ra = 5'(r_a); ore = o_e;
      we = w_e; wa = 5'(w_a); wmask = w_m; di = d_i;
      pwr = $urandom;
      for (int k = 0; k < 2; k++) begin
         if (!r_n) begin
            m_rd[k] = '0; m_rdv[k] = 1'b0; m_out[k] = '0; m_outv[k] = 1'b0;
            m_cnt[k] = 0; m_busy[k] = 1'b1;
         end else begin
            if (OREG[k] != 0 && o_e) begin
               m_out[k] = m_rd[k];
               if (m_rdv[k]) m_outv[k] = 1'b1;
            end
            if (m_busy[k]) begin
               m_mem[k][m_cnt[k]] = '0;
               if (m_cnt[k] == D - 1) begin
                  m_busy[k] = 1'b0;
                  m_cnt[k]  = 0;
               end else begin
                  m_cnt[k]++;
               end
            end else begin
               if (r_e) begin
                  if (r_a < D) begin
                     m_rd[k] = m_mem[k][r_a];
                     if (BYP[k] != 0 && w_e && w_a == r_a)
                        m_rd[k] = merge(m_rd[k], d_i, w_m);
                  end else begin
                     m_rd[k] = '0;
                  end
                  m_rdv[k] = 1'b1;
               end
               if (w_e && w_a < D) m_mem[k][w_a] = merge(m_mem[k][w_a], d_i, w_m);
            end
         end
      end
      e.dout_a = (OREG[0] != 0) ? m_out[0] : m_rd[0];
      e.vld_a  = (OREG[0] != 0) ? m_outv[0] : m_rdv[0];
      e.dout_b = (OREG[1] != 0) ? m_out[1] : m_rd[1];
      e.vld_b  = (OREG[1] != 0) ? m_outv[1] : m_rdv[1];
      e.busy_a = m_busy[0];
      e.busy_b = m_busy[1];
      e.cyc    = cyc;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic o_e);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, o_e, 1'b0, 0, 4'h0, '0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv, input int c);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, c, act, expv);
      end
   endtask

   // Monitor: one expectation per issued cycle, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("dout_a", dout_a, e.dout_a, e.cyc);
            chk("vld_a",  32'(vld_a),  32'(e.vld_a),  e.cyc);
            chk("busy_a", 32'(busy_a), 32'(e.busy_a), e.cyc);
            chk("dout_b", dout_b, e.dout_b, e.cyc);
            chk("vld_b",  32'(vld_b),  32'(e.vld_b),  e.cyc);
            chk("busy_b", 32'(busy_b), 32'(e.busy_b), e.cyc);
         end
      end
   end

   initial begin
      int n;
      int a, b;
      logic r_n;
      rstn = 1'b0; re = 1'b0; ra = '0; ore = 1'b0; we = 1'b0; wa = '0;
      wmask = '0; di = '0; pwr = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < D; i++) m_mem[k][i] = '0;
         m_rd[k] = '0; m_rdv[k] = 1'b0; m_out[k] = '0; m_outv[k] = 1'b0;
         m_busy[k] = 1'b1; m_cnt[k] = 0;
      end

      // Reset with live traffic: must be ignored.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3, 1'b1, 1'b1, 3, 4'hF, 32'hDEAD_BEEF);
      // Partial clear, reset again mid-sequence, then a full clear.
      idle(10, 1'b1);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 4'h0, '0);
      idle(D + 3, 1'b1);

      // Basic write then read.
      step(1'b1, 1'b0, 0, 1'b1, 1'b1, 3, 4'hF, 32'hA5A5_A5A5);
      step(1'b1, 1'b1, 3, 1'b1, 1'b0, 0, 4'h0, '0);
      idle(2, 1'b1);

      // Collision with single-segment mask.
      step(1'b1, 1'b0, 0, 1'b1, 1'b1, 5, 4'hF, 32'h1111_1111);
      step(1'b1, 1'b1, 5, 1'b1, 1'b1, 5, 4'h1, 32'hFFFF_FFFF);
      idle(2, 1'b1);
      step(1'b1, 1'b1, 5, 1'b1, 1'b0, 0, 4'h0, '0);
      idle(2, 1'b1);

      // Output register held off by ore.
      step(1'b1, 1'b0, 0, 1'b1, 1'b1, 7, 4'hF, 32'h7777_7777);
      step(1'b1, 1'b1, 7, 1'b0, 1'b0, 0, 4'h0, '0);
      idle(3, 1'b0);
      idle(2, 1'b1);

      // Out-of-range write/read must not alias onto the low words.
      step(1'b1, 1'b0, 0, 1'b1, 1'b1, 9, 4'hF, 32'h9999_9999);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1, 25, 4'hF, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 25, 1'b1, 1'b0, 0, 4'h0, '0);
      step(1'b1, 1'b1, 9, 1'b1, 1'b0, 0, 4'h0, '0);
      idle(2, 1'b1);

      // Read back every word, including zero-filled ones.
      for (int i = 0; i < D; i++) step(1'b1, 1'b1, i, 1'b1, 1'b0, 0, 4'h0, '0);
      idle(2, 1'b1);

      // Random traffic with frequent collisions and rare resets.
      for (int i = 0; i < 600; i++) begin
         a = $urandom_range(0, 23);
         b = ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 23);
         r_n = ($urandom_range(0, 149) != 0);
         step(r_n, 1'($urandom), a, 1'($urandom), 1'($urandom), b,
              4'($urandom), $urandom);
      end
      idle(3, 1'b1);

      n = 0;
      while (exp_q.size() != 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nv_ram_rwsp_gen.md
NV_RAM_RWSP_GEN -- requirements
Module: nv_ram_rwsp_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of words (>=2, power of two not required).
REQ-002 SHALL have parameter WIDTH, default 128, word width in bits.
REQ-003 SHALL have parameter SEG_W, default 8, write-mask segment width; WIDTH SHALL be a multiple of SEG_W; NSEG = WIDTH/SEG_W.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds an output pipeline stage gated by ore.
REQ-005 SHALL have parameter BYPASS, default 0; 1 = write-first on read/write collision, 0 = read-first.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 0; 1 = zero-fill all words after reset.
REQ-007 SHALL have parameter AW = max(1, clog2(DEPTH)), derived, not overridden.
REQ-008 clk  input  1  sole clock; all state updates on posedge.
REQ-009 rstn  input  1  reset, synchronous, active-low.
REQ-010 ra  input  AW  read address.
REQ-011 re  input  1  read enable.
REQ-012 ore  input  1  output-register enable (ignored when OUT_REG=0).
REQ-013 dout  output  WIDTH  read data.
REQ-014 dout_vld  output  1  dout holds data from a completed read.
REQ-015 wa  input  AW  write address.
REQ-016 we  input  1  write enable.
REQ-017 wmask  input  NSEG  per-segment write enable; bit i covers di[i*SEG_W +: SEG_W].
REQ-018 di  input  WIDTH  write data.
REQ-019 busy  output  1  clear sequence in progress; re/we ignored.
REQ-020 pwrbus_ram_pd  input  32  power-domain control; functionally ignored, kept for drop-in compatibility.

Function
REQ-021 Memory array SHALL be DEPTH x WIDTH, inferred as block RAM; contents not reset unless CLEAR_ON_RESET=1.
REQ-022 On posedge with we=1, !busy, wa<DEPTH: segments with wmask bit set SHALL be written; others unchanged; wmask=0 is a no-op.
REQ-023 On posedge with re=1, !busy, ra<DEPTH: read register rd_q SHALL load M[ra]; dout visible next cycle (latency 1) when OUT_REG=0.
REQ-024 rd_q SHALL hold its value while re=0; later writes to the same address SHALL NOT alter rd_q.
REQ-025 Collision (re, we, ra==wa, same cycle): BYPASS=0 -> rd_q gets pre-write data; BYPASS=1 -> per segment, di if wmask bit set else old data.
REQ-026 Out-of-range address (>=DEPTH): write SHALL be dropped; read SHALL load zero into rd_q.
REQ-027 OUT_REG=1: out_q SHALL load rd_q on posedge with ore=1; dout=out_q; re->ore->dout latency 2 when ore asserted the cycle after re.
REQ-028 dout_vld (OUT_REG=0): set on any accepted read, held thereafter until reset.
REQ-029 dout_vld (OUT_REG=1): set when ore loads out_q from a valid rd_q, held until reset.
REQ-030 FSM states CLEAR, RUN; reset -> CLEAR if CLEAR_ON_RESET=1 else RUN.
REQ-031 CLEAR: write all-zero to address cnt, cnt 0..DEPTH-1 one per cycle; after DEPTH-1 go to RUN; busy=1 exactly DEPTH cycles.
REQ-032 Reset asserted mid-CLEAR SHALL restart the clear from address 0.

Reset
REQ-033 While rstn=0 at posedge: rd_q=0, out_q=0, dout=0, dout_vld=0, cnt=0, busy=CLEAR_ON_RESET.
REQ-034 Reads/writes presented in the reset cycle SHALL be ignored.

Structure
REQ-035 Shared package nv_ram_pkg SHALL hold clog2 function and FSM state enum (ST_CLEAR, ST_RUN).
REQ-036 Single flat module; no sub-module; array, read stage, output stage, clear FSM in one file.

Verification
REQ-037 Default params: write wa=3 di=0xA5.. full mask, next cycle re ra=3 -> dout=0xA5.. one cycle later, dout_vld=1.
REQ-038 BYPASS=0 vs 1: M[5]=0x11..11, collision write 0xFF..FF mask=0x0001 -> dout 0x11..11 vs 0x11..11FF.
REQ-039 OUT_REG=1: read addr 7 (0x77..), ore held 0 for 3 cycles -> dout stays 0; ore=1 -> dout=0x77.. next cycle.
REQ-040 CLEAR_ON_RESET=1, DEPTH=32: release rstn -> busy high 32 cycles; then read every address -> all zero.
REQ-041 Reset mid-CLEAR at cnt=10 -> busy stays high 32 more cycles after release.
REQ-042 DEPTH=20: write wa=25 then read ra=25 -> dout=0; M[9] (25 mod 16) unchanged.
